// File: rtl/lif_neuron_array.sv
// Time-multiplexed array of leaky integrate-and-fire neurons sharing one saturating
// datapath, with per-neuron membrane/refractory state and valid/ready streaming.
module lif_neuron_array #(
  parameter int N_NEURONS  = 16,
  parameter int DATA_W     = 32,
  parameter int LEAK_SHIFT = 5,
  parameter int REFRAC_W   = 4,
  localparam int IDX_W     = $clog2(N_NEURONS)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                clear,
  input  logic                cfg_load,
  input  logic [DATA_W-1:0]   cfg_threshold,
  input  logic                cfg_reset_mode,
  input  logic [REFRAC_W-1:0] cfg_refrac,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_current,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IDX_W-1:0]    out_idx,
  output logic                out_spike,
  output logic [DATA_W-1:0]   out_mem,
  output logic                out_last,
  output logic                err_seq
);

  localparam int EXT_W = DATA_W + 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);
  localparam logic [DATA_W-1:0] THR_DEFAULT = DATA_W'(1) << (DATA_W / 2);
  localparam logic [DATA_W-1:0] DATA_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] DATA_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  function automatic logic signed [EXT_W-1:0] sext(input logic signed [DATA_W-1:0] x);
    return {{2{x[DATA_W-1]}}, x};
  endfunction

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [EXT_W-1:0] x);
    logic signed [EXT_W-1:0] hi;
    logic signed [EXT_W-1:0] lo;
    hi = sext(DATA_MAX);
    lo = sext(DATA_MIN);
    if (x > hi) begin
      return DATA_MAX;
    end else if (x < lo) begin
      return DATA_MIN;
    end else begin
      return x[DATA_W-1:0];
    end
  endfunction

  logic signed [DATA_W-1:0] mem_r [N_NEURONS];
  logic [REFRAC_W-1:0]      refr_r [N_NEURONS];
  logic [IDX_W-1:0]         idx_r;
  logic                     err_seq_r;
  logic signed [DATA_W-1:0] thr_r;
  logic                     mode_r;
  logic [REFRAC_W-1:0]      refrac_r;

  logic                     out_valid_r;
  logic [IDX_W-1:0]         out_idx_r;
  logic                     out_spike_r;
  logic [DATA_W-1:0]        out_mem_r;
  logic                     out_last_r;

  logic                     accept_s;
  logic                     fire_s;
  logic                     seq_bad_s;
  logic signed [DATA_W-1:0] v_s;
  logic signed [DATA_W-1:0] diff_s;
  logic signed [DATA_W-1:0] va_s;
  logic signed [DATA_W-1:0] cur_s;
  logic signed [DATA_W-1:0] vn_s;
  logic [REFRAC_W-1:0]      r_s;
  logic [REFRAC_W-1:0]      refr_nx_s;
  logic [IDX_W-1:0]         idx_nx_s;

  assign in_ready  = !clear && (!out_valid_r || out_ready);
  assign accept_s  = in_valid && in_ready;
  assign out_valid = out_valid_r;
  assign out_idx   = out_idx_r;
  assign out_spike = out_spike_r;
  assign out_mem   = out_mem_r;
  assign out_last  = out_last_r;
  assign err_seq   = err_seq_r;

  // Shared neuron update datapath for the neuron selected by idx_r.
  always_comb begin
    v_s       = mem_r[idx_r];
    r_s       = refr_r[idx_r];
    fire_s    = (r_s == {REFRAC_W{1'b0}}) && (v_s > thr_r);
    diff_s    = sat(sext(v_s) - sext(thr_r));
    va_s      = v_s;
    cur_s     = {DATA_W{1'b0}};
    refr_nx_s = r_s;
    if (fire_s) begin
      if (mode_r) begin
        va_s = {DATA_W{1'b0}};
      end else begin
        va_s = diff_s;
      end
    end else begin
      va_s = v_s;
    end
    // A neuron in refractory ignores its input but keeps leaking.
    if (r_s == {REFRAC_W{1'b0}}) begin
      cur_s = $signed(in_current);
    end else begin
      cur_s = {DATA_W{1'b0}};
    end
    vn_s = sat(sext(va_s) - sext(va_s >>> LEAK_SHIFT) + sext(cur_s));
    if (fire_s) begin
      refr_nx_s = refrac_r;
    end else if (r_s != {REFRAC_W{1'b0}}) begin
      refr_nx_s = r_s - REFRAC_W'(1);
    end else begin
      refr_nx_s = r_s;
    end
  end

  // Neuron index sequencing and misalignment detection.
  always_comb begin
    idx_nx_s  = idx_r;
    seq_bad_s = in_last != (idx_r == LAST_IDX);
    if (in_last) begin
      idx_nx_s = {IDX_W{1'b0}};
    end else if (idx_r == LAST_IDX) begin
      idx_nx_s = {IDX_W{1'b0}};
    end else begin
      idx_nx_s = idx_r + IDX_W'(1);
    end
  end

  // Index and sticky sequence-error registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx_r     <= {IDX_W{1'b0}};
      err_seq_r <= 1'b0;
    end else if (clear) begin
      idx_r     <= {IDX_W{1'b0}};
      err_seq_r <= 1'b0;
    end else if (accept_s) begin
      idx_r     <= idx_nx_s;
      err_seq_r <= err_seq_r | seq_bad_s;
    end
  end

  // Per-neuron membrane and refractory state file.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        mem_r[i]  <= {DATA_W{1'b0}};
        refr_r[i] <= {REFRAC_W{1'b0}};
      end
    end else if (clear) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        mem_r[i]  <= {DATA_W{1'b0}};
        refr_r[i] <= {REFRAC_W{1'b0}};
      end
    end else if (accept_s) begin
      mem_r[idx_r]  <= vn_s;
      refr_r[idx_r] <= refr_nx_s;
    end
  end

  // Output stage: holds while stalled, reloads on accept even when draining.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_r <= 1'b0;
      out_idx_r   <= {IDX_W{1'b0}};
      out_spike_r <= 1'b0;
      out_mem_r   <= {DATA_W{1'b0}};
      out_last_r  <= 1'b0;
    end else if (clear) begin
      out_valid_r <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_idx_r   <= idx_r;
      out_spike_r <= fire_s;
      out_mem_r   <= vn_s;
      out_last_r  <= in_last;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  // Configuration registers; untouched by clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      thr_r    <= THR_DEFAULT;
      mode_r   <= 1'b0;
      refrac_r <= {REFRAC_W{1'b0}};
    end else if (cfg_load) begin
      thr_r    <= cfg_threshold;
      mode_r   <= cfg_reset_mode;
      refrac_r <= cfg_refrac;
    end
  end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Self-checking bench for lif_neuron_array (N=4, Q16.16): directed scenarios plus
// randomized traffic against a cycle-level arithmetic reference model.
module tb_lif_neuron_array;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int LS = 5;
  localparam int RW = 4;
  localparam int IW = 2;
  localparam longint MAXV = (longint'(1) <<< (DW - 1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (DW - 1));

  logic          clk = 1'b0;
  logic          resetn, clear, cfg_load, cfg_reset_mode;
  logic [DW-1:0] cfg_threshold, in_current;
  logic [RW-1:0] cfg_refrac;
  logic          in_valid, in_ready, in_last, out_valid, out_ready;
  logic [IW-1:0] out_idx;
  logic          out_spike, out_last, err_seq;
  logic [DW-1:0] out_mem;

  lif_neuron_array #(.N_NEURONS(N), .DATA_W(DW), .LEAK_SHIFT(LS), .REFRAC_W(RW)) dut (
    .clk(clk), .resetn(resetn), .clear(clear), .cfg_load(cfg_load),
    .cfg_threshold(cfg_threshold), .cfg_reset_mode(cfg_reset_mode), .cfg_refrac(cfg_refrac),
    .in_valid(in_valid), .in_ready(in_ready), .in_current(in_current), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_spike(out_spike),
    .out_mem(out_mem), .out_last(out_last), .err_seq(err_seq)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model state
  longint m_mem [N];
  int     m_refr [N];
  int     m_idx;
  bit     m_err;
  longint m_thr;
  bit     m_mode;
  int     m_refrac;
  bit     m_ov, m_ospk, m_olast;
  int     m_oidx;
  longint m_omem;

  function automatic longint clamp(input longint x);
    if (x > MAXV) return MAXV;
    if (x < MINV) return MINV;
    return x;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      m_mem[i] = 0;
      m_refr[i] = 0;
    end
    m_idx = 0; m_err = 0; m_thr = 64'sd65536; m_mode = 0; m_refrac = 0;
    m_ov = 0; m_ospk = 0; m_olast = 0; m_oidx = 0; m_omem = 0;
  endtask

  task automatic m_beat();
    longint v, va, vn, cur;
    int r;
    bit fire;
    v = m_mem[m_idx];
    r = m_refr[m_idx];
    fire = (r == 0) && (v > m_thr);
    if (!fire) va = v;
    else if (m_mode) va = 0;
    else va = clamp(v - m_thr);
    cur = (r == 0) ? longint'($signed(in_current)) : 64'sd0;
    vn = clamp(va - (va >>> LS) + cur);
    m_refr[m_idx] = fire ? m_refrac : ((r > 0) ? r - 1 : 0);
    m_mem[m_idx] = vn;
    m_ov = 1; m_oidx = m_idx; m_ospk = fire; m_omem = vn; m_olast = in_last;
    if (in_last != (m_idx == N - 1)) m_err = 1;
    m_idx = in_last ? 0 : (m_idx + 1) % N;
  endtask

  // One clock cycle with the inputs currently driven; model advances and outputs are checked.
  task automatic cycle();
    bit rdy, acc;
    #1;
    rdy = !clear && (!m_ov || out_ready);
    chk("in_ready", 64'(in_ready), 64'(rdy));
    acc = in_valid && rdy;
    @(posedge clk);
    #1;
    if (clear) begin
      for (int i = 0; i < N; i++) begin
        m_mem[i] = 0;
        m_refr[i] = 0;
      end
      m_idx = 0; m_err = 0; m_ov = 0;
    end else if (acc) begin
      m_beat();
    end else if (out_ready) begin
      m_ov = 0;
    end
    if (cfg_load) begin
      m_thr = longint'($signed(cfg_threshold));
      m_mode = cfg_reset_mode;
      m_refrac = int'(cfg_refrac);
    end
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    chk("err_seq", 64'(err_seq), 64'(m_err));
    if (m_ov) begin
      chk("out_idx", 64'(out_idx), 64'(m_oidx));
      chk("out_spike", 64'(out_spike), 64'(m_ospk));
      chk("out_mem", 64'(out_mem), 64'(m_omem[DW-1:0]));
      chk("out_last", 64'(out_last), 64'(m_olast));
    end
  endtask

  task automatic beat(input logic [DW-1:0] cur, input bit last);
    in_valid = 1'b1; in_current = cur; in_last = last; out_ready = 1'b1;
    cycle();
  endtask

  task automatic do_clear();
    clear = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    clear = 1'b0; in_valid = 1'b0;
  endtask

  task automatic load_cfg(input logic [DW-1:0] thr, input bit mode, input logic [RW-1:0] rf);
    cfg_threshold = thr; cfg_reset_mode = mode; cfg_refrac = rf; cfg_load = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    cfg_load = 1'b0;
  endtask

  // One timestep: neuron 0 gets c0, others 0; neuron 0 result checked against a fixed value.
  task automatic run_ts(input logic [DW-1:0] c0, input logic [63:0] exp0, input bit spk0);
    for (int i = 0; i < N; i++) begin
      beat((i == 0) ? c0 : '0, i == N - 1);
      if (i == 0) begin
        chk("n0_mem", 64'(out_mem), exp0);
        chk("n0_spike", 64'(out_spike), 64'(spk0));
      end else begin
        chk("nx_mem", 64'(out_mem), 64'h0);
      end
    end
  endtask

  initial begin
    int ndel;
    resetn = 1'b0; clear = 1'b0; cfg_load = 1'b0; cfg_threshold = '0; cfg_reset_mode = 1'b0;
    cfg_refrac = '0; in_valid = 1'b0; in_current = '0; in_last = 1'b0; out_ready = 1'b1;
    m_reset();
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_idx", 64'(out_idx), 64'h0);
    chk("rst_out_mem", 64'(out_mem), 64'h0);
    chk("rst_out_spike", 64'(out_spike), 64'h0);
    chk("rst_out_last", 64'(out_last), 64'h0);
    chk("rst_err_seq", 64'(err_seq), 64'h0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // defaults: integrate, fire with subtract reset
    run_ts(32'h8000, 64'h8000, 1'b0);
    run_ts(32'h8000, 64'hFC00, 1'b0);
    run_ts(32'h8000, 64'h17420, 1'b0);
    run_ts(32'h8000, 64'hF07F, 1'b1);

    // zero reset with refractory period of 2
    do_clear();
    load_cfg(32'h10000, 1'b1, 4'd2);
    run_ts(32'h8000, 64'h8000, 1'b0);
    run_ts(32'h8000, 64'hFC00, 1'b0);
    run_ts(32'h8000, 64'h17420, 1'b0);
    run_ts(32'h8000, 64'h8000, 1'b1);
    run_ts(32'h8000, 64'h7C00, 1'b0);
    run_ts(32'h8000, 64'h7820, 1'b0);

    // saturation at both rails
    do_clear();
    load_cfg(32'h7FFFFFFF, 1'b0, 4'd0);
    for (int t = 0; t < 3 * N; t++) begin
      beat(32'h7FFFFFFF, (t % N) == N - 1);
      chk("sat_hi_mem", 64'(out_mem), 64'h7FFFFFFF);
      chk("sat_hi_spike", 64'(out_spike), 64'h0);
    end
    do_clear();
    for (int t = 0; t < 3 * N; t++) begin
      beat(32'h80000000, (t % N) == N - 1);
      chk("sat_lo_mem", 64'(out_mem), 64'h80000000);
    end

    // backpressure: out_ready toggling, in_valid held
    do_clear();
    load_cfg(32'h10000, 1'b0, 4'd0);
    ndel = 0;
    in_valid = 1'b1;
    for (int c = 0; c < 32; c++) begin
      out_ready = (c % 2) == 0;
      in_last = (m_idx == N - 1);
      in_current = 32'($urandom_range(0, 32'h20000));
      if (out_valid && out_ready) begin
        chk("bp_idx", 64'(out_idx), 64'(ndel % N));
        chk("bp_last", 64'(out_last), 64'((ndel % N) == N - 1));
        ndel++;
      end
      cycle();
    end
    chk("bp_delivered", 64'(ndel), 64'd15);
    in_valid = 1'b0; out_ready = 1'b1;
    cycle();

    // misaligned in_last, then clear
    do_clear();
    beat(32'h100, 1'b0);
    beat(32'h200, 1'b1);
    chk("seq_err_set", 64'(err_seq), 64'h1);
    beat(32'h300, 1'b0);
    chk("seq_next_idx", 64'(out_idx), 64'h0);
    do_clear();
    chk("seq_err_clr", 64'(err_seq), 64'h0);
    beat(32'h1234, 1'b0);
    chk("clr_mem", 64'(out_mem), 64'h1234);

    // cfg_load alongside an accepted beat uses the old threshold
    do_clear();
    load_cfg(32'h10000, 1'b0, 4'd0);
    beat(32'h18000, 1'b0);
    beat(32'h18000, 1'b0);
    beat(32'h0, 1'b0);
    beat(32'h0, 1'b1);
    cfg_threshold = 32'h20000; cfg_load = 1'b1;
    beat(32'h0, 1'b0);
    chk("cfg_old_thr_spike", 64'(out_spike), 64'h1);
    cfg_load = 1'b0;
    beat(32'h0, 1'b0);
    chk("cfg_new_thr_spike", 64'(out_spike), 64'h0);
    beat(32'h0, 1'b0);
    beat(32'h0, 1'b1);

    // randomized traffic
    do_clear();
    load_cfg(32'($urandom_range(32'h8000, 32'h40000)), 1'($urandom), 4'($urandom_range(0, 3)));
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      in_current = 32'($urandom_range(0, 32'h30000)) - 32'h8000;
      if ($urandom % 20 == 0) in_current = $urandom;
      in_last = (m_idx == N - 1) ^ (($urandom % 25) == 0);
      cfg_load = ($urandom % 40) == 0;
      cfg_threshold = 32'($urandom_range(32'h8000, 32'h40000));
      cfg_reset_mode = 1'($urandom);
      cfg_refrac = 4'($urandom_range(0, 3));
      clear = ($urandom % 60) == 0;
      cycle();
    end
    clear = 1'b0; cfg_load = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cycle();

    // asynchronous reset while a result is pending
    load_cfg(32'h20000, 1'b1, 4'd3);
    in_valid = 1'b1; in_current = 32'h5000; in_last = 1'b0; out_ready = 1'b0;
    cycle();
    in_valid = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'h0);
    chk("arst_out_mem", 64'(out_mem), 64'h0);
    chk("arst_out_idx", 64'(out_idx), 64'h0);
    chk("arst_err_seq", 64'(err_seq), 64'h0);
    m_reset();
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      beat(32'h0, i == N - 1);
      chk("arst_state_mem", 64'(out_mem), 64'h0);
      chk("arst_state_idx", 64'(out_idx), 64'(i));
    end
    run_ts(32'h18000, 64'h18000, 1'b0);
    run_ts(32'h0, 64'h7C00, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lif_neuron_array.md
# lif_neuron_array

Time-multiplexed array of N leaky integrate-and-fire neurons sharing one datapath. Each accepted input beat updates one neuron's membrane from a per-neuron state register file. Compared with the single-neuron LIF it adds:
- parametrised width, neuron count and leak;
- selectable subtract/zero reset;
- a refractory period;
- saturating arithmetic;
- valid/ready streaming in and out.

It sits between the synaptic-weight accumulator (upstream current stream) and the spike encoder/readout (downstream).

## Interface
Parameters:
- N_NEURONS, 16, neuron count (>=2); IDX_W = $clog2(N_NEURONS)
- DATA_W, 32, signed fixed-point width of membrane, current and threshold (Q16.16 at default)
- LEAK_SHIFT, 5, leak factor 1 - 2^-LEAK_SHIFT per update
- REFRAC_W, 4, refractory counter width

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous clear of all neuron state and index
- cfg_load  in  1  capture cfg_* into config registers
- cfg_threshold  in  DATA_W  signed firing threshold
- cfg_reset_mode  in  1  0 = subtract threshold on fire, 1 = reset to zero
- cfg_refrac  in  REFRAC_W  refractory updates after a fire
- in_valid  in  1  current beat valid
- in_ready  out  1  block accepts beat
- in_current  in  DATA_W  signed input current for current neuron
- in_last  in  1  marks last neuron of the timestep
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_idx  out  IDX_W  neuron index of result
- out_spike  out  1  neuron fired this update
- out_mem  out  DATA_W  post-update membrane
- out_last  out  1  copy of in_last for this beat
- err_seq  out  1  sticky: in_last misaligned with index N_NEURONS-1

## Operation
- Internal index idx selects the neuron.
  - +1 per accepted beat; wraps N_NEURONS-1 -> 0.
  - An accepted beat with in_last=1 forces idx to 0 next.
- Sequence checking:
  - err_seq sets when in_last=1 with idx != N_NEURONS-1.
  - err_seq also sets when idx == N_NEURONS-1 with in_last=0.
  - It clears only on resetn or clear.
- Per accepted beat, for neuron i, with v = mem[i] and r = refr[i]:
  - fire = (r == 0) && (v > thr), a signed compare on the pre-update v.
  - va = fire ? (mode ? 0 : v - thr) : v.
  - vn = sat(va - (va >>> LEAK_SHIFT) + (r == 0 ? in_current : 0)).
    - Computed in DATA_W+2 bits; saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
    - The subtraction v - thr is also saturated.
  - Refractory counter: fire -> refr[i] = cfg_refrac; else r > 0 -> refr[i] = r - 1.
  - During refractory the input is ignored, but leak still applies.
- Writeback: mem[i] = vn. The output register loads idx, fire, vn, in_last.
- Config:
  - cfg_load captures all cfg_* into config registers.
  - A beat accepted in the same cycle uses the old config.
- clear:
  - Zeroes mem, refr, idx, err_seq and out_valid.
  - Config is untouched.
  - in_ready = 0 while clear = 1; clear wins over any handshake.

## Timing
- Handshake rules:
  - Accept = in_valid && in_ready.
  - in_ready = !clear && (!out_valid || out_ready).
  - Output held stable while out_valid && !out_ready.
- Latency: result appears 1 cycle after accept.
- Throughput: 1 beat/cycle with out_ready = 1.
- Back-to-back updates of the same neuron (N_NEURONS >= 2) never collide; no forwarding needed.
- Reset values:
  - out_valid = 0, out_spike = 0, out_idx = 0, out_mem = 0, out_last = 0, err_seq = 0.
  - mem[*] = 0, refr[*] = 0, idx = 0.
  - Config: threshold = 1.0 (1 << DATA_W/2), mode = 0, refrac = 0.
- A reset mid-stream discards the in-flight output beat immediately.
- Simultaneous out_ready and a new accept: the output register reloads that cycle, with no bubble.

## Test plan
- Defaults, N=4: drive neuron 0 with 0x8000 each timestep, others 0.
  - Neuron 0 out_mem: 0x8000, 0xFC00, 0x17420.
  - 4th update: out_spike = 1 and out_mem = 0xF07F; all other neurons stay 0.
- Same stimulus with cfg_reset_mode = 1 and cfg_refrac = 2.
  - On the fire beat out_mem = 0x8000.
  - The next two updates ignore input (out_mem 0x7C00, 0x7820); no spike possible.
- Saturation: cfg_threshold = 0x7FFFFFFF, in_current = 0x7FFFFFFF repeatedly.
  - out_mem pins at 0x7FFFFFFF with no wrap and no spike.
  - Repeat with current 0x80000000: out_mem pins at 0x80000000.
- Backpressure: out_ready toggles 1/0 every cycle with in_valid held high.
  - Every beat is delivered once, in order: out_idx 0,1,2,3 repeating.
  - out_last only on idx 3; no beat lost or duplicated.
- in_last asserted on idx 1: err_seq = 1 and the next result is out_idx = 0.
  - A subsequent clear zeroes err_seq and all membranes (next out_mem = in_current).
- cfg_load in the same cycle as an accepted beat: that beat fires against the old threshold; the following beat uses the new one.
- resetn asserted with out_valid = 1: out_valid drops asynchronously and all state reads back 0.
